gb_csr_bank: RTL

- Parametrised host-accessible register/RAM bank on the ghostbus local bus. Generalises the single-register, single-RAM leaf to:
  - NREG control registers;
  - a sticky status word with write-1-to-clear;
  - a dual-ported RAM, host-writable and fabric-readable;
  - a configurable read-pipeline depth.
- Sits as a leaf under any submodule. The read-data output is zero when not addressed, so parents OR-combine sibling outputs.

---
 rtl/gb_pkg.sv | 23 ++
 rtl/gb_csr_bank_if.sv | 28 ++
 rtl/gb_rd_pipe.sv | 37 +++
 rtl/gb_csr_bank.sv | 120 ++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared ghostbus definitions: fixed offsets, hit classification and a
// constant-evaluable clog2 for sizing address fields.
package gb_pkg;

  localparam int unsigned STAT_OFF = 'h1F;

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_REG,
    HIT_STAT,
    HIT_RAM
  } hit_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gb_csr_bank_if.sv
// Ghostbus host port bundle: word address, write/read data and strobes.
//
// Handshake: there is no ready. wstb and rstb are single-cycle strobes the
// leaf must accept in the cycle they are high (wstb only acts when we=1).
// A read strobe at cycle T returns exactly one rvalid pulse RL cycles later,
// with din holding the data in that cycle and zero in every other cycle.
interface gb_csr_bank_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;
  logic          we;
  logic          wstb;
  logic          rstb;
  logic          rvalid;

  modport master (
    output addr, dout, we, wstb, rstb,
    input  din, rvalid
  );

  modport slave (
    input  addr, dout, we, wstb, rstb,
    output din, rvalid
  );
endinterface

// File: rtl/gb_rd_pipe.sv
// RL-stage valid/data delay line with synchronous flush. Data travels as zero
// whenever its valid bit is low, so the output can feed an OR-tree directly.
module gb_rd_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned RL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          vld [RL];
  logic [DW-1:0] dat [RL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RL; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int unsigned i = 1; i < RL; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RL-1];
  assign out_data  = dat[RL-1];

endmodule

// File: rtl/gb_csr_bank.sv
// Ghostbus leaf: NREG control registers, a write-1-to-clear sticky status
// word and a host-written / fabric-read RAM, behind a fixed-latency read path.
module gb_csr_bank
  import gb_pkg::*;
#(
  parameter int unsigned   AW      = 24,
  parameter int unsigned   DW      = 32,
  parameter int unsigned   GW      = 8,
  parameter int unsigned   NREG    = 4,
  parameter logic [GW-1:0] RST_VAL = GW'(8'h42),
  parameter int unsigned   NSTAT   = 8,
  parameter int unsigned   RW      = 4,
  parameter int unsigned   RD      = 8,
  parameter logic [AW-1:0] BASE    = '0,
  parameter logic [AW-1:0] RAM_OFF = AW'('h40),
  parameter int unsigned   RL      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gb_csr_bank_if.slave          GBPORT,
  output logic [NREG*GW-1:0]    ctrl_out,
  input  logic [NSTAT-1:0]      status_in,
  input  logic [clog2(RD)-1:0]  ram_raddr,
  output logic [RW-1:0]         ram_rdata
);

  localparam int unsigned   RAW     = clog2(RD);
  localparam int unsigned   RIW     = (NREG > 1) ? clog2(NREG) : 1;
  localparam logic [AW-1:0] NREG_A  = AW'(NREG);
  localparam logic [AW-1:0] STAT_A  = AW'(STAT_OFF);
  localparam logic [AW-1:0] RAM_END = RAM_OFF + AW'(RD);

  logic [AW-1:0]    off;
  hit_e             hit;
  logic [RIW-1:0]   reg_idx;
  logic [RAW-1:0]   ram_idx;
  logic             wr_en;
  logic             rd_en;

  logic [GW-1:0]    regs [NREG];
  logic [NSTAT-1:0] sticky;
  logic [NSTAT-1:0] stat_clr;
  logic [RW-1:0]    ram [RD];
  logic [DW-1:0]    rd_data;

  // Strobes arriving while rst is high are dropped, not deferred.
  assign wr_en   = GBPORT.we & GBPORT.wstb & ~rst;
  assign rd_en   = GBPORT.rstb & ~rst;

  assign off     = GBPORT.addr - BASE;
  assign reg_idx = off[RIW-1:0];
  assign ram_idx = off[RAW-1:0];

  always_comb begin
    hit = HIT_NONE;
    if (off < NREG_A) begin
      hit = HIT_REG;
    end else if (off == STAT_A) begin
      hit = HIT_STAT;
    end else if ((off >= RAM_OFF) && (off < RAM_END)) begin
      hit = HIT_RAM;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREG; k++) regs[k] <= RST_VAL;
    end else if (wr_en && (hit == HIT_REG)) begin
      regs[reg_idx] <= GBPORT.dout[GW-1:0];
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_ctrl
    assign ctrl_out[k*GW +: GW] = regs[k];
  end

  // Sticky status: a new event in the same cycle as its clear keeps the bit.
  assign stat_clr = (wr_en && (hit == HIT_STAT)) ? GBPORT.dout[NSTAT-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~stat_clr) | status_in;
    end
  end

  // RAM is never reset; the fabric port reads the pre-write word on collision.
  always_ff @(posedge clk) begin
    if (wr_en && (hit == HIT_RAM)) begin
      ram[ram_idx] <= GBPORT.dout[RW-1:0];
    end
    ram_rdata <= ram[ram_raddr];
  end

  // Host read data is sampled from current state, so same-cycle writes are unseen.
  always_comb begin
    rd_data = '0;
    case (hit)
      HIT_REG:  rd_data[GW-1:0]    = regs[reg_idx];
      HIT_STAT: rd_data[NSTAT-1:0] = sticky;
      HIT_RAM:  rd_data[RW-1:0]    = ram[ram_idx];
      default:  rd_data            = '0;
    endcase
  end

  gb_rd_pipe #(
    .DW (DW),
    .RL (RL)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (rd_data),
    .out_valid (GBPORT.rvalid),
    .out_data  (GBPORT.din)
  );

endmodule
